// File: rtl/multicycle_ctrl.sv
// Main control FSM for a multicycle RV32 subset (lw, sw, R, I-ALU, beq, jal, lui).
// A unified memory with a MemReady handshake stretches FETCH, MEMREAD and MEMWRITE.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       Halted
);

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpBeq = 7'b1100011;
  localparam logic [6:0] OpJal = 7'b1101111;
  localparam logic [6:0] OpLui = 7'b0110111;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR,
    StExecI, StAluWb, StBeq, StJal, StLui, StHalt
  } state_e;

  state_e state_q, state_d;
  logic   pc_we, ir_we, mem_we, reg_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    Halted    = 1'b0;
    unique case (state_q)
      StFetch: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_we     = MemReady;
        ir_we     = MemReady;
        if (MemReady) state_d = StDecode;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExecR;
          OpI:        state_d = StExecI;
          OpBeq:      state_d = StBeq;
          OpJal:      state_d = StJal;
          OpLui:      state_d = StLui;
          default:    state_d = StHalt;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OpLw) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
        if (MemReady) state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        reg_we    = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        AdrSrc = 1'b1;
        mem_we = 1'b1;
        if (MemReady) state_d = StFetch;
      end
      StExecR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = StAluWb;
      end
      StExecI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = StAluWb;
      end
      StAluWb: begin
        reg_we  = 1'b1;
        state_d = StFetch;
      end
      StBeq: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        pc_we   = Zero;
        state_d = StFetch;
      end
      StJal: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_we   = 1'b1;
        state_d = StAluWb;
      end
      StLui: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        state_d = StAluWb;
      end
      StHalt: begin
        Halted = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    case (op)
      OpSw:    ImmSrc = 3'b001;
      OpBeq:   ImmSrc = 3'b010;
      OpJal:   ImmSrc = 3'b011;
      OpLui:   ImmSrc = 3'b100;
      default: ImmSrc = 3'b000;
    endcase
  end

  // Reset forces FETCH asynchronously, but FETCH strobes follow MemReady, so gate them too.
  assign PCWrite  = pc_we  & ~reset;
  assign IRWrite  = ir_we  & ~reset;
  assign MemWrite = mem_we & ~reset;
  assign RegWrite = reg_we & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle vector table walks every instruction
// class, followed by hand-written HALT and asynchronous-reset sequences.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0000011;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Halted;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;

  multicycle_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .Zero     (Zero),
    .MemReady (MemReady),
    .PCWrite  (PCWrite),
    .AdrSrc   (AdrSrc),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .ResultSrc(ResultSrc),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .ImmSrc   (ImmSrc),
    .RegWrite (RegWrite),
    .Halted   (Halted)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpBeq = 7'b1100011;
  localparam logic [6:0] OpJal = 7'b1101111;
  localparam logic [6:0] OpLui = 7'b0110111;
  localparam logic [6:0] OpBad = 7'b1111111;

  // Word layout: {PCWrite,AdrSrc,MemWrite,IRWrite}_ResultSrc_ALUSrcA_ALUSrcB_ALUOp_{RegWrite,Halted}
  localparam logic [13:0] WFetchR  = 14'b1001_10_00_10_00_00;
  localparam logic [13:0] WFetchW  = 14'b0000_10_00_10_00_00;
  localparam logic [13:0] WDecode  = 14'b0000_00_01_01_00_00;
  localparam logic [13:0] WMemAdr  = 14'b0000_00_10_01_00_00;
  localparam logic [13:0] WMemRead = 14'b0100_00_00_00_00_00;
  localparam logic [13:0] WMemWb   = 14'b0000_01_00_00_00_10;
  localparam logic [13:0] WMemWr   = 14'b0110_00_00_00_00_00;
  localparam logic [13:0] WExecR   = 14'b0000_00_10_00_10_00;
  localparam logic [13:0] WExecI   = 14'b0000_00_10_01_10_00;
  localparam logic [13:0] WAluWb   = 14'b0000_00_00_00_00_10;
  localparam logic [13:0] WBeqT    = 14'b1000_00_10_00_01_00;
  localparam logic [13:0] WBeqN    = 14'b0000_00_10_00_01_00;
  localparam logic [13:0] WJal     = 14'b1000_00_01_10_00_00;
  localparam logic [13:0] WLui     = 14'b0000_00_11_01_00_00;
  localparam logic [13:0] WHalt    = 14'b0000_00_00_00_00_01;

  typedef struct {
    logic [6:0]  op;
    logic        z;
    logic        mr;
    logic [13:0] w;
    logic [2:0]  imm;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic add(input logic [6:0] o, input logic z, input logic mr, input logic [13:0] w,
                     input logic [2:0] imm, input string name);
    vec_t v;
    v.op = o; v.z = z; v.mr = mr; v.w = w; v.imm = imm; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [13:0] w, input logic [2:0] imm);
    logic [16:0] got, exp;
    got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
           RegWrite, Halted, ImmSrc};
    exp = {w, imm};
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b required %b", name, got, exp);
  endtask

  task automatic cyc(input logic [6:0] o, input logic z, input logic mr);
    @(negedge clk);
    op = o; Zero = z; MemReady = mr;
    #1;
  endtask

  initial begin
    // lw, no wait: 5 cycles
    add(OpLw, 0, 1, WFetchR, 3'b000, "lw_fetch");
    add(OpLw, 0, 1, WDecode, 3'b000, "lw_decode");
    add(OpLw, 0, 1, WMemAdr, 3'b000, "lw_memadr");
    add(OpLw, 0, 1, WMemRead, 3'b000, "lw_memread");
    add(OpLw, 0, 1, WMemWb, 3'b000, "lw_memwb");
    // sw with 3 wait cycles in MEMWRITE
    add(OpSw, 0, 1, WFetchR, 3'b001, "sw_fetch");
    add(OpSw, 0, 1, WDecode, 3'b001, "sw_decode");
    add(OpSw, 0, 1, WMemAdr, 3'b001, "sw_memadr");
    add(OpSw, 0, 0, WMemWr, 3'b001, "sw_memwr_w1");
    add(OpSw, 0, 0, WMemWr, 3'b001, "sw_memwr_w2");
    add(OpSw, 0, 0, WMemWr, 3'b001, "sw_memwr_w3");
    add(OpSw, 0, 1, WMemWr, 3'b001, "sw_memwr_done");
    // R-type with one fetch wait
    add(OpR, 0, 0, WFetchW, 3'b000, "r_fetch_wait");
    add(OpR, 0, 1, WFetchR, 3'b000, "r_fetch");
    add(OpR, 0, 1, WDecode, 3'b000, "r_decode");
    add(OpR, 0, 1, WExecR, 3'b000, "r_execr");
    add(OpR, 0, 1, WAluWb, 3'b000, "r_aluwb");
    add(OpI, 1, 1, WFetchR, 3'b000, "i_fetch");
    add(OpI, 1, 1, WDecode, 3'b000, "i_decode");
    add(OpI, 1, 1, WExecI, 3'b000, "i_execi");
    add(OpI, 1, 1, WAluWb, 3'b000, "i_aluwb");
    add(OpBeq, 1, 1, WFetchR, 3'b010, "beqt_fetch");
    add(OpBeq, 1, 1, WDecode, 3'b010, "beqt_decode");
    add(OpBeq, 1, 1, WBeqT, 3'b010, "beqt_beq");
    add(OpBeq, 0, 1, WFetchR, 3'b010, "beqn_fetch");
    add(OpBeq, 0, 1, WDecode, 3'b010, "beqn_decode");
    add(OpBeq, 0, 1, WBeqN, 3'b010, "beqn_beq");
    add(OpJal, 0, 1, WFetchR, 3'b011, "jal_fetch");
    add(OpJal, 0, 1, WDecode, 3'b011, "jal_decode");
    add(OpJal, 0, 1, WJal, 3'b011, "jal_jal");
    add(OpJal, 0, 1, WAluWb, 3'b011, "jal_aluwb");
    add(OpLui, 0, 1, WFetchR, 3'b100, "lui_fetch");
    add(OpLui, 0, 1, WDecode, 3'b100, "lui_decode");
    add(OpLui, 0, 1, WLui, 3'b100, "lui_lui");
    add(OpLui, 0, 1, WAluWb, 3'b100, "lui_aluwb");
    // lw with one wait in MEMREAD: 6 cycles
    add(OpLw, 0, 1, WFetchR, 3'b000, "lww_fetch");
    add(OpLw, 0, 1, WDecode, 3'b000, "lww_decode");
    add(OpLw, 0, 1, WMemAdr, 3'b000, "lww_memadr");
    add(OpLw, 0, 0, WMemRead, 3'b000, "lww_memread_w");
    add(OpLw, 0, 1, WMemRead, 3'b000, "lww_memread");
    add(OpLw, 0, 1, WMemWb, 3'b000, "lww_memwb");
    add(OpBad, 1, 1, WFetchR, 3'b000, "bad_fetch");
    add(OpBad, 1, 1, WDecode, 3'b000, "bad_decode");

    // Reset held with MemReady=1 must still suppress FETCH strobes
    MemReady = 1'b1;
    @(negedge clk); #1;
    check("reset_hold", WFetchW, 3'b000);
    @(negedge clk); #1;
    check("reset_hold2", WFetchW, 3'b000);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i == 0) reset = 1'b0;
      op = vecs[i].op; Zero = vecs[i].z; MemReady = vecs[i].mr;
      #1;
      check($sformatf("vec%0d_%s", i, vecs[i].name), vecs[i].w, vecs[i].imm);
    end

    // HALT absorbs for 10 cycles whatever the inputs do
    for (int i = 0; i < 10; i++) begin
      cyc(OpBad, i[0], ~i[1]);
      check($sformatf("halt_c%0d", i), WHalt, 3'b000);
    end
    // Async reset pulse out of HALT
    #2 reset = 1'b1; MemReady = 1'b1;
    #1 check("halt_reset", WFetchW, 3'b000);
    cyc(OpSw, 0, 1);
    reset = 1'b0;
    #1 check("halt_post_fetch", WFetchR, 3'b001);
    cyc(OpSw, 0, 1);
    check("rs_decode", WDecode, 3'b001);
    cyc(OpSw, 0, 1);
    check("rs_memadr", WMemAdr, 3'b001);
    cyc(OpSw, 0, 0);
    check("rs_memwr_wait", WMemWr, 3'b001);
    // Async reset mid-MEMWRITE: MemWrite must drop without a clock edge
    #2 reset = 1'b1;
    #1 check("rs_memwr_abort", WFetchW, 3'b001);
    cyc(OpSw, 0, 1);
    check("rs_hold_mr1", WFetchW, 3'b001);
    cyc(OpSw, 0, 1);
    reset = 1'b0;
    #1 check("rs_post_fetch", WFetchR, 3'b001);
    cyc(OpSw, 0, 1);
    check("rs_post_decode", WDecode, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
